// File: rtl/beep_driver.sv
// Buzzer pattern generator: plays beep_count tone bursts separated by silent gaps, then pulses done.
// Optional BEEP_ABORT_EN adds an abort input that cancels a running pattern without done.
module beep_driver #(
    parameter int unsigned TONE_DIV   = 25000,
    parameter int unsigned ON_CYCLES  = 5000000,
    parameter int unsigned OFF_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] beep_count,
`ifdef BEEP_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       buzzer,
    output logic       done
);

    localparam int unsigned PhaseMax = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned PW       = $clog2(PhaseMax + 1);
    localparam int unsigned TW       = $clog2(TONE_DIV + 1);

    localparam logic [PW-1:0] OnLast   = PW'(ON_CYCLES - 1);
    localparam logic [PW-1:0] OffLast  = PW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] ToneLast = TW'(TONE_DIV - 1);

    typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [TW-1:0] tone_q, tone_d;
    logic [2:0]    rem_q, rem_d;
    logic          buzzer_q, buzzer_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          abort_req;

`ifdef BEEP_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Outputs are computed one cycle ahead so every pin comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        tone_d   = tone_q;
        rem_d    = rem_q;
        buzzer_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && beep_count != 3'd0) begin
                    state_d  = StOn;
                    rem_d    = beep_count;
                    phase_d  = '0;
                    tone_d   = '0;
                    buzzer_d = 1'b1;
                end
            end
            StOn: begin
                if (abort_req) begin
                    state_d = StIdle;
                end else if (phase_q == OnLast) begin
                    phase_d = '0;
                    if (rem_q > 3'd1) begin
                        rem_d   = rem_q - 3'd1;
                        state_d = StOff;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                    if (tone_q == ToneLast) begin
                        tone_d   = '0;
                        buzzer_d = ~buzzer_q;
                    end else begin
                        tone_d   = tone_q + 1'b1;
                        buzzer_d = buzzer_q;
                    end
                end
            end
            StOff: begin
                if (abort_req) begin
                    state_d = StIdle;
                end else if (phase_q == OffLast) begin
                    state_d  = StOn;
                    phase_d  = '0;
                    tone_d   = '0;
                    buzzer_d = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            tone_q   <= '0;
            rem_q    <= '0;
            buzzer_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            tone_q   <= tone_d;
            rem_q    <= rem_d;
            buzzer_q <= buzzer_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign buzzer = buzzer_q;
    assign done   = done_q;

endmodule

// File: tb/tb_beep_driver.sv
// Scoreboard bench for beep_driver: stimulus pushes per-cycle expected outputs, a monitor checks them.
module tb_beep_driver;

    localparam int unsigned TD  = 2;
    localparam int unsigned ONC = 6;
    localparam int unsigned OFC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] beep_count = 3'd0;
`ifdef BEEP_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       busy, buzzer, done;

    beep_driver #(.TONE_DIV(TD), .ON_CYCLES(ONC), .OFF_CYCLES(OFC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .beep_count (beep_count),
`ifdef BEEP_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .buzzer     (buzzer),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic busy;
        logic buz;
        logic done;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   model_free = 0;  // first cycle in which a new start is accepted (the done cycle)
    int   pat_start = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle is an output; cycles with no queued entry must be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            while (q.size() != 0 && q[0].cyc < cyc) begin
                void'(q.pop_front());
                n_tests++;
                n_fail++;
                $display("FAIL stale_entry cyc=%0d: expected entry never matched", cyc);
            end
            e = '{cyc, 1'b0, 1'b0, 1'b0};
            if (q.size() != 0 && q[0].cyc == cyc) e = q.pop_front();
            n_tests++;
            if (busy !== e.busy || buzzer !== e.buz || done !== e.done) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d: got busy=%b buzzer=%b done=%b, want %b %b %b",
                         cyc, busy, buzzer, done, e.busy, e.buz, e.done);
            end
        end
    end

    function automatic void flush(input int from);
        while (q.size() != 0 && q[$].cyc >= from) void'(q.pop_back());
    endfunction

    // Reference pattern: beep b occupies k in [b*(ON+OFF), b*(ON+OFF)+ON); tone level from k/TONE_DIV parity.
    function automatic void push_pattern(input int s, input int n);
        int len = n * ONC + (n - 1) * OFC;
        for (int k = 0; k < len; k++) begin
            int r = k % (ONC + OFC);
            logic bz = (r < ONC) && ((r / TD) % 2 == 0);
            q.push_back('{s + k, 1'b1, bz, 1'b0});
        end
        q.push_back('{s + len, 1'b0, 1'b0, 1'b1});
        pat_start  = s;
        model_free = s + len;
    endfunction

    task automatic drive(input logic st, input logic [2:0] cnt, input logic r, input logic ab);
        int  c = cyc;
        bit  mbusy = (c >= pat_start) && (c < model_free);
        start      = st;
        beep_count = cnt;
        rst        = r;
`ifdef BEEP_ABORT_EN
        abort      = ab;
`endif
        if (r) begin
            flush(c + 1);
            model_free = c + 1;
        end else if (ab && mbusy) begin
            flush(c + 1);
            model_free = c + 1;
        end else if (st && cnt != 3'd0 && c >= model_free) begin
            push_pattern(c + 1, int'(cnt));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
`ifdef BEEP_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        mon_en = 1'b1;
        idle(2);
        // One beep, then two beeps
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        idle(10);
        drive(1'b1, 3'd2, 1'b0, 1'b0);
        idle(20);
        // Zero count ignored; count 7 during a 2-beep pattern ignored
        drive(1'b1, 3'd0, 1'b0, 1'b0);
        idle(3);
        drive(1'b1, 3'd2, 1'b0, 1'b0);
        idle(4);
        drive(1'b1, 3'd7, 1'b0, 1'b0);
        idle(20);
        // Reset in OFF of beep 1 of 3, with start held alongside
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        idle(7);
        drive(1'b1, 3'd5, 1'b1, 1'b0);
        idle(5);
        // Back-to-back: second start lands in the done cycle
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        idle(6);
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        idle(10);
`ifdef BEEP_ABORT_EN
        // Abort at ON index 3 of beep 1 of 2, then a normal beep
        drive(1'b1, 3'd2, 1'b0, 1'b0);
        idle(3);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        idle(3);
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        idle(10);
`endif
        for (int it = 0; it < 200; it++) begin
            int op = int'($urandom_range(0, 19));
            idle(int'($urandom_range(0, 25)));
            if (op == 0) begin
                drive(1'b1, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
            end else if (op == 1) begin
`ifdef BEEP_ABORT_EN
                drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0, 1'b1);
`else
                drive(1'b0, 3'd0, 1'b0, 1'b0);
`endif
            end else begin
                drive(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
            end
        end
        for (int i = 0; i < 200 && cyc <= model_free + 2; i++) idle(1);
        idle(2);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
